event_tx: RTL and testbench
===========================

# event_tx

Transmit end of the event path: accepts filtered DVS events (x, y, t, polarity), buffers them in a small FIFO, and emits each event as a 3-byte frame on an 8-bit valid/ready byte stream toward the chip output pins. It sits directly downstream of the event filter and is the sole producer of the off-chip event byte stream.

## Interface
- FIFO_DEPTH, 4: event buffer entries; power of two, 2..16.
- X_W, 4: x coordinate width; fixed at 4 by frame format.
- Y_W, 4: y coordinate width; fixed at 4 by frame format.
- T_W, 8: timestamp width; fixed at 8 by frame format.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ev_valid  in  1  event present this cycle; no backpressure on this side.
- ev_x  in  4  event x coordinate.
- ev_y  in  4  event y coordinate.
- ev_t  in  8  event timestamp.
- ev_p  in  1  event polarity.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready.
- tx_sof  out  1  current byte is frame byte 0.
- tx_eof  out  1  current byte is frame byte 2.
- ovf  out  1  sticky: an event was dropped since reset.
- drop_cnt  out  8  dropped-event count (see Configuration).

## Operation
- Frame format: byte0 = {1'b1, p, seq[1:0], x[3:0]}; byte1 = {4'h0, y[3:0]}; byte2 = t[7:0].
- seq: 2-bit frame counter, increments when byte2 is accepted; wraps 3->0; reset 0.
- Push: ev_valid && !full writes {p,x,y,t} into FIFO. ev_valid && full drops the event, sets ovf, and counts the drop. A push on a full FIFO is dropped even if a pop occurs the same cycle.
- FSM states IDLE, B0, B1, B2.
  - IDLE: if FIFO non-empty, pop head into frame register, build bytes, go to B0; otherwise stay.
  - B0/B1: drive byte0/byte1, tx_valid=1; on tx_ready advance to B1/B2; otherwise hold.
  - B2: drive byte2, tx_valid=1; on tx_ready increment seq; if FIFO non-empty, pop next event and go to B0 (back-to-back frames); otherwise go to IDLE.
- tx_data, tx_sof, tx_eof are stable while tx_valid && !tx_ready. tx_valid never drops mid-frame except on reset.
- tx_sof=1 only in B0; tx_eof=1 only in B2; both are 0 when tx_valid=0.
- Reset values: tx_data 0, tx_valid 0, tx_sof 0, tx_eof 0, ovf 0, drop_cnt 0, seq 0, FIFO empty, state IDLE.
- Reset mid-frame: partial frame abandoned; FIFO contents discarded; outputs return to reset values at the edge that samples rst_n=0.

## Timing
- Outputs are registered; no combinational path from ev_* or tx_ready to any output.
- Latency, empty FIFO and IDLE: ev_valid in cycle N -> FIFO write at end of N -> pop in N+1 -> tx_valid=1 with byte0 in N+2.
- Throughput: 3 cycles per event with tx_ready held high; no idle cycle between back-to-back frames.
- Sustained input above 1 event per 3 cycles overflows after FIFO_DEPTH events plus the event held in the frame register.

## Configuration
- EVENT_TX_DROP_CNT_EN defined: drop_cnt is an 8-bit counter, incremented on each dropped event, saturating at 255, cleared only by reset.
- Not defined: drop_cnt is tied to 8'h00 and the counter is not built; the port stays present and ovf behaviour is unchanged.

## Structure
- Shared package event_pkg: X_W/Y_W/T_W constants, event struct {p,x,y,t}, frame header bit 1'b1, FSM state enum.
- Sub-module event_fifo: synchronous single-clock FIFO (push, pop, din, dout, full, empty) with depth FIFO_DEPTH. Both the push side and the pop side can act in the same cycle.

## Test plan
- Single event x=4'hA, y=4'h3, t=8'h5C, p=1 with tx_ready=1 -> bytes 8'hCA (sof), 8'h03, 8'h5C (eof) in cycles N+2..N+4; seq advances to 1.
- tx_ready low for 5 cycles during B1 -> tx_data holds 8'h03 and tx_valid stays 1; frame completes after tx_ready rises.
- 4 frames sent back-to-back -> seq fields are 0,1,2,3, then the 5th frame's byte0 carries seq 0 (wrap); no gap cycles between frames.
- tx_ready=0 with 7 ev_valid pulses -> 1 event in the frame register, 4 in the FIFO, 2 dropped; ovf=1; drop_cnt=2 with EVENT_TX_DROP_CNT_EN, otherwise drop_cnt=0.
- rst_n low during B1 -> next cycle tx_valid=0, FIFO empty, seq=0, ovf=0; a new event after reset produces a complete frame with seq 0.
- 300 drops with EVENT_TX_DROP_CNT_EN -> drop_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/event_pkg.sv
// Shared types and constants for the event transmit path: event record,
// frame header bit, transmit FSM states and frame byte builders.
package event_pkg;

    localparam int unsigned X_W = 4;
    localparam int unsigned Y_W = 4;
    localparam int unsigned T_W = 8;

    localparam logic FRAME_HDR = 1'b1;

    typedef struct packed {
        logic           p;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [T_W-1:0] t;
    } event_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_B0,
        ST_B1,
        ST_B2
    } tx_state_e;

    function automatic logic [7:0] frame_byte0(input event_t ev, input logic [1:0] seq);
        return {FRAME_HDR, ev.p, seq, ev.x};
    endfunction

    function automatic logic [7:0] frame_byte1(input event_t ev);
        return {4'h0, ev.y};
    endfunction

    function automatic logic [7:0] frame_byte2(input event_t ev);
        return ev.t;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Single-clock event FIFO; push and pop may both act in the same cycle.
// Pointers carry one extra wrap bit to tell full from empty.
module event_fifo
    import event_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  event_t din,
    output event_t dout,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    event_t      mem_q [DEPTH];
    event_t      mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/event_tx.sv
// Event transmitter: buffers DVS events and emits 3-byte frames on a
// valid/ready byte stream. EVENT_TX_DROP_CNT_EN builds the drop counter.
module event_tx
    import event_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned X_W        = event_pkg::X_W,
    parameter int unsigned Y_W        = event_pkg::Y_W,
    parameter int unsigned T_W        = event_pkg::T_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ev_valid,
    input  logic [X_W-1:0] ev_x,
    input  logic [Y_W-1:0] ev_y,
    input  logic [T_W-1:0] ev_t,
    input  logic           ev_p,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           tx_sof,
    output logic           tx_eof,
    output logic           ovf,
    output logic [7:0]     drop_cnt
);

    tx_state_e  state_q, state_d;
    event_t     frame_q, frame_d;
    logic [1:0] seq_q, seq_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       tx_sof_q, tx_sof_d;
    logic       tx_eof_q, tx_eof_d;
    logic       ovf_q, ovf_d;

    event_t fifo_din;
    event_t fifo_dout;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;
    logic   drop;

    assign fifo_din = '{p: ev_p, x: ev_x, y: ev_y, t: ev_t};
    // A full FIFO drops the event even when a pop frees a slot this cycle.
    assign push = ev_valid && !fifo_full;
    assign drop = ev_valid && fifo_full;

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        seq_d      = seq_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_sof_d   = tx_sof_q;
        tx_eof_d   = tx_eof_q;
        pop        = 1'b0;
        ovf_d      = ovf_q | drop;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    frame_d    = fifo_dout;
                    tx_data_d  = frame_byte0(fifo_dout, seq_q);
                    tx_valid_d = 1'b1;
                    tx_sof_d   = 1'b1;
                    tx_eof_d   = 1'b0;
                    state_d    = ST_B0;
                end
            end
            ST_B0: begin
                if (tx_ready) begin
                    tx_data_d = frame_byte1(frame_q);
                    tx_sof_d  = 1'b0;
                    state_d   = ST_B1;
                end
            end
            ST_B1: begin
                if (tx_ready) begin
                    tx_data_d = frame_byte2(frame_q);
                    tx_eof_d  = 1'b1;
                    state_d   = ST_B2;
                end
            end
            ST_B2: begin
                if (tx_ready) begin
                    seq_d    = seq_q + 2'd1;
                    tx_eof_d = 1'b0;
                    // Chain straight into the next frame so there is no gap cycle.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        frame_d   = fifo_dout;
                        tx_data_d = frame_byte0(fifo_dout, seq_q + 2'd1);
                        tx_sof_d  = 1'b1;
                        state_d   = ST_B0;
                    end else begin
                        tx_data_d  = '0;
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            seq_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_sof_q   <= 1'b0;
            tx_eof_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            seq_q      <= seq_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_sof_q   <= tx_sof_d;
            tx_eof_q   <= tx_eof_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_sof   = tx_sof_q;
    assign tx_eof   = tx_eof_q;
    assign ovf      = ovf_q;

`ifdef EVENT_TX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_event_tx.sv
// Directed bench for event_tx: framing, stall, back-to-back, overflow,
// mid-frame reset and drop-counter saturation.
module tb_event_tx;

`ifdef EVENT_TX_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ev_valid;
    logic [3:0] ev_x;
    logic [3:0] ev_y;
    logic [7:0] ev_t;
    logic       ev_p;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sof;
    logic       tx_eof;
    logic       ovf;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    event_tx #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_valid (ev_valid),
        .ev_x     (ev_x),
        .ev_y     (ev_y),
        .ev_t     (ev_t),
        .ev_p     (ev_p),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_sof   (tx_sof),
        .tx_eof   (tx_eof),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_ev(input logic [3:0] x, input logic [3:0] y,
                           input logic [7:0] t, input logic p);
        ev_x = x; ev_y = y; ev_t = t; ev_p = p;
        ev_valid = 1'b1;
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic test_reset();
        tx_ready = 1'b1;
        do_reset();
        checks++;
        if ({tx_valid, tx_sof, tx_eof, ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got v/sof/eof/ovf=%b required 0000", {tx_valid, tx_sof, tx_eof, ovf});
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h required 00", tx_data);
        end
        checks++;
        if (drop_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %h required 00", drop_cnt);
        end
    endtask

    task automatic test_single();
        tx_ready = 1'b1;
        send_ev(4'hA, 4'h3, 8'h5C, 1'b1);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop_cycle_valid: got %b required 0", tx_valid);
        end
        tick();
        checks++;
        if ({tx_valid, tx_sof, tx_eof, tx_data} !== {3'b110, 8'hCA}) begin
            errors++;
            $display("FAIL single_byte0: got v/sof/eof=%b data=%h required 110 CA", {tx_valid, tx_sof, tx_eof}, tx_data);
        end
        tick();
        checks++;
        if ({tx_valid, tx_sof, tx_eof, tx_data} !== {3'b100, 8'h03}) begin
            errors++;
            $display("FAIL single_byte1: got v/sof/eof=%b data=%h required 100 03", {tx_valid, tx_sof, tx_eof}, tx_data);
        end
        tick();
        checks++;
        if ({tx_valid, tx_sof, tx_eof, tx_data} !== {3'b101, 8'h5C}) begin
            errors++;
            $display("FAIL single_byte2: got v/sof/eof=%b data=%h required 101 5C", {tx_valid, tx_sof, tx_eof}, tx_data);
        end
        tick();
        checks++;
        if ({tx_valid, tx_sof, tx_eof} !== 3'b000) begin
            errors++;
            $display("FAIL single_idle_after: got v/sof/eof=%b required 000", {tx_valid, tx_sof, tx_eof});
        end
    endtask

    // seq is 1 here, so byte0 = {1,0,01,0101} = 8'h95.
    task automatic test_stall();
        tx_ready = 1'b1;
        send_ev(4'h5, 4'h3, 8'h11, 1'b0);
        tick();
        checks++;
        if ({tx_valid, tx_sof, tx_data} !== {2'b11, 8'h95}) begin
            errors++;
            $display("FAIL stall_byte0_seq1: got v/sof=%b data=%h required 11 95", {tx_valid, tx_sof}, tx_data);
        end
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({tx_valid, tx_sof, tx_eof, tx_data} !== {3'b100, 8'h03}) begin
                errors++;
                $display("FAIL stall_hold_b1[%0d]: got v/sof/eof=%b data=%h required 100 03", i, {tx_valid, tx_sof, tx_eof}, tx_data);
            end
            tick();
        end
        tx_ready = 1'b1;
        checks++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h03}) begin
            errors++;
            $display("FAIL stall_release_b1: got v=%b data=%h required 1 03", tx_valid, tx_data);
        end
        tick();
        checks++;
        if ({tx_valid, tx_eof, tx_data} !== {2'b11, 8'h11}) begin
            errors++;
            $display("FAIL stall_byte2: got v/eof=%b data=%h required 11 11", {tx_valid, tx_eof}, tx_data);
        end
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle_after: got %b required 0", tx_valid);
        end
    endtask

    // seq is 2 here; first held frame byte0 = {1,1,10,0000} = 8'hE0.
    task automatic test_overflow();
        int frames;
        tx_ready = 1'b0;
        for (int j = 0; j < 7; j++) begin
            ev_x = 4'(j); ev_y = 4'(j); ev_t = 8'h20 + 8'(j); ev_p = 1'b1;
            ev_valid = 1'b1;
            tick();
            if (j == 4) begin
                checks++;
                if (ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_before_drop: got %b required 0", ovf);
                end
            end
        end
        ev_valid = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b required 1", ovf);
        end
        checks++;
        if (drop_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin
            errors++;
            $display("FAIL ovf_drop_cnt: got %0d required %0d", drop_cnt, CNT_EN ? 2 : 0);
        end
        checks++;
        if ({tx_valid, tx_sof, tx_data} !== {2'b11, 8'hE0}) begin
            errors++;
            $display("FAIL ovf_held_byte0: got v/sof=%b data=%h required 11 E0", {tx_valid, tx_sof}, tx_data);
        end
        tx_ready = 1'b1;
        frames = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid && tx_eof) frames++;
            tick();
        end
        checks++;
        if (frames !== 5) begin
            errors++;
            $display("FAIL ovf_drained_frames: got %0d required 5", frames);
        end
        checks++;
        if ({tx_valid, ovf} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_after_drain: got v/ovf=%b required 01", {tx_valid, ovf});
        end
    endtask

    // seq is 3 here; byte0 = {1,0,11,0111} = 8'hB7.
    task automatic test_reset_mid_frame();
        tx_ready = 1'b1;
        send_ev(4'h7, 4'h9, 8'h42, 1'b0);
        tick();
        checks++;
        if (tx_data !== 8'hB7) begin
            errors++;
            $display("FAIL rstmid_byte0: got %h required B7", tx_data);
        end
        tick();
        checks++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h09}) begin
            errors++;
            $display("FAIL rstmid_in_b1: got v=%b data=%h required 1 09", tx_valid, tx_data);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({tx_valid, tx_sof, tx_eof, ovf, tx_data, drop_cnt} !== {4'b0000, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL rstmid_outputs: got v/sof/eof/ovf=%b data=%h drop=%h required 0000 00 00", {tx_valid, tx_sof, tx_eof, ovf}, tx_data, drop_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_fifo_empty[%0d]: got v=%b required 0", i, tx_valid);
            end
        end
        send_ev(4'h1, 4'h2, 8'h33, 1'b1);
        tick();
        checks++;
        if ({tx_valid, tx_sof, tx_data} !== {2'b11, 8'hC1}) begin
            errors++;
            $display("FAIL rstmid_new_byte0_seq0: got v/sof=%b data=%h required 11 C1", {tx_valid, tx_sof}, tx_data);
        end
        tick();
        checks++;
        if (tx_data !== 8'h02) begin
            errors++;
            $display("FAIL rstmid_new_byte1: got %h required 02", tx_data);
        end
        tick();
        checks++;
        if ({tx_eof, tx_data} !== {1'b1, 8'h33}) begin
            errors++;
            $display("FAIL rstmid_new_byte2: got eof=%b data=%h required 1 33", tx_eof, tx_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b;
        logic [3:0] x_k;
        logic       p_k;
        logic [1:0] seq_k;
        do_reset();
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ev_x = 4'(k + 3); ev_y = 4'(k); ev_t = 8'h80 + 8'(k); ev_p = k[0];
            ev_valid = 1'b1;
            tick();
        end
        ev_valid = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            x_k   = 4'(k + 3);
            p_k   = k[0];
            seq_k = 2'(k % 4);
            for (int b = 0; b < 3; b++) begin
                if (b == 0)      exp_b = {1'b1, p_k, seq_k, x_k};
                else if (b == 1) exp_b = {4'h0, 4'(k)};
                else             exp_b = 8'h80 + 8'(k);
                checks++;
                if ({tx_valid, tx_sof, tx_eof, tx_data} !== {1'b1, (b == 0), (b == 2), exp_b}) begin
                    errors++;
                    $display("FAIL b2b_frame%0d_byte%0d: got v/sof/eof=%b data=%h required sof=%0d eof=%0d data=%h",
                             k, b, {tx_valid, tx_sof, tx_eof}, tx_data, (b == 0), (b == 2), exp_b);
                end
                tick();
            end
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_after: got %b required 0", tx_valid);
        end
    endtask

    task automatic test_drop_saturation();
        do_reset();
        tx_ready = 1'b0;
        ev_x = 4'hF; ev_y = 4'hF; ev_t = 8'hFF; ev_p = 1'b0;
        ev_valid = 1'b1;
        // Five events are absorbed (frame register + 4 FIFO slots), then every cycle drops.
        for (int i = 0; i < 305; i++) begin
            tick();
            if (i == 258) begin
                checks++;
                if (drop_cnt !== (CNT_EN ? 8'hFE : 8'h00)) begin
                    errors++;
                    $display("FAIL sat_254_drops: got %h required %h", drop_cnt, CNT_EN ? 8'hFE : 8'h00);
                end
            end
            if (i == 259) begin
                checks++;
                if (drop_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin
                    errors++;
                    $display("FAIL sat_255_drops: got %h required %h", drop_cnt, CNT_EN ? 8'hFF : 8'h00);
                end
            end
        end
        ev_valid = 1'b0;
        checks++;
        if (drop_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin
            errors++;
            $display("FAIL sat_300_drops: got %h required %h", drop_cnt, CNT_EN ? 8'hFF : 8'h00);
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf: got %b required 1", ovf);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        ev_x     = '0;
        ev_y     = '0;
        ev_t     = '0;
        ev_p     = 1'b0;
        tx_ready = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_reset_mid_frame();
        test_back_to_back();
        test_drop_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
